// File: rtl/led_bank_pkg.sv
// Shared constants and types for the instruction-driven LED bank.
// Instructions are {opcode, immediate}; opcodes above LD7 are illegal.
package led_bank_pkg;

  localparam int LedBank_OpcodeW = 4;
  localparam int LedBank_ImmW    = 8;
  localparam int LedBank_InstW   = LedBank_OpcodeW + LedBank_ImmW;

  localparam logic [LedBank_OpcodeW-1:0] LedBank_NOP = 4'h0;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LDI = 4'h1;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD0 = 4'h2;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD1 = 4'h3;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD2 = 4'h4;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD3 = 4'h5;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD4 = 4'h6;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD5 = 4'h7;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD6 = 4'h8;
  localparam logic [LedBank_OpcodeW-1:0] LedBank_LD7 = 4'h9;

  typedef enum logic {
    LedBank_State_Ready = 1'b0,
    LedBank_State_Error = 1'b1
  } led_bank_state_e;

endpackage

// File: rtl/led_bank_if.sv
// Instruction bus between the sequencer (master) and the LED bank (slave).
// inst is sampled only when inst_en is 1; there is no backpressure, so one instruction per clock is always accepted.
interface led_bank_if;
  import led_bank_pkg::*;

  logic [LedBank_InstW-1:0] inst;
  logic                     inst_en;
  logic [LedBank_ImmW-1:0]  leds;
  led_bank_state_e          state;

  modport slave (
    input  inst,
    input  inst_en,
    output leds,
    output state
  );

  modport master (
    output inst,
    output inst_en,
    input  leds,
    input  state
  );
endinterface

// File: rtl/led_bank.sv
// Eight-LED output register driven by instructions; an illegal opcode latches a sticky ERROR state with LEDs forced off.
// LEDs and state come straight from flops.
module led_bank
  import led_bank_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  led_bank_if.slave   bus
);

  led_bank_state_e           state_q, state_d;
  logic [LedBank_ImmW-1:0]   leds_q, leds_d;
  logic [LedBank_OpcodeW-1:0] opcode;
  logic [LedBank_ImmW-1:0]   imm;
  logic [2:0]                ld_idx;

  assign opcode = bus.inst[LedBank_InstW-1:LedBank_ImmW];
  assign imm    = bus.inst[LedBank_ImmW-1:0];
  assign ld_idx = 3'(opcode - LedBank_LD0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LedBank_State_Ready;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
    end
  end

  // ERROR holds everything: leds were cleared on entry and nothing is decoded afterwards.
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    if (state_q == LedBank_State_Ready && bus.inst_en) begin
      case (opcode)
        LedBank_NOP: ;
        LedBank_LDI: leds_d = imm;
        LedBank_LD0, LedBank_LD1, LedBank_LD2, LedBank_LD3,
        LedBank_LD4, LedBank_LD5, LedBank_LD6, LedBank_LD7:
          leds_d[ld_idx] = imm[0];
        default: begin
          state_d = LedBank_State_Error;
          leds_d  = '0;
        end
      endcase
    end
  end

  assign bus.leds  = leds_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_led_bank.sv
// Bench for led_bank: directed walk through the documented instruction sequence, then randomized instructions
// against a behavioural model of the LED register and its error flag.
module tb_led_bank;
  import led_bank_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  led_bank_if bus();

  led_bank dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] m_leds;
  bit         m_err;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_leds = 8'h00;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input int op, input logic [7:0] imm);
    int n;
    if (!en || m_err) return;
    if (op == 0) begin
    end else if (op == 1) begin
      m_leds = imm;
    end else if (op >= 2 && op <= 9) begin
      n = op - 2;
      if (imm[0]) m_leds = m_leds | (8'h01 << n);
      else        m_leds = m_leds & ~(8'h01 << n);
    end else begin
      m_err  = 1'b1;
      m_leds = 8'h00;
    end
  endfunction

  task automatic exec(input string tag, input bit en, input logic [3:0] op, input logic [7:0] imm);
    @(negedge clock);
    bus.inst_en = en;
    bus.inst    = {op, imm};
    model_step(en, int'(op), imm);
    exp_q.push_back(m_leds);
    @(posedge clock);
    #1;
    check_eq(tag, bus.leds, exp_q.pop_front());
    check_eq({tag, "_state"}, {7'b0, bus.state}, {7'b0, m_err});
  endtask

  task automatic exec_want(input string tag, input bit en, input logic [3:0] op,
                           input logic [7:0] imm, input logic [7:0] want);
    exec(tag, en, op, imm);
    check_eq({tag, "_const"}, bus.leds, want);
  endtask

  task automatic reset_pulse(input int len_ns);
    @(negedge clock);
    bus.inst_en = 1'b0;
    reset = 1'b0;
    #(len_ns);
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_leds", bus.leds, 8'h00);
    check_eq("rst_state", {7'b0, bus.state}, 8'h00);
  endtask

  initial begin
    logic [3:0] op;
    bit         en;
    reset       = 1'b0;
    bus.inst_en = 1'b0;
    bus.inst    = '0;
    model_reset();
    #4;
    reset = 1'b1;
    #0.5;
    check_eq("por_leds", bus.leds, 8'h00);
    check_eq("por_state", {7'b0, bus.state}, 8'h00);

    exec_want("nop0", 1, LedBank_NOP, 8'h00, 8'h00);
    exec_want("ldi2c", 1, LedBank_LDI, 8'h2C, 8'h2C);
    exec_want("ld0", 1, LedBank_LD0, 8'h01, 8'h2D);
    exec_want("ld1", 1, LedBank_LD1, 8'hFF, 8'h2F);
    exec_want("ld2", 1, LedBank_LD2, 8'hFE, 8'h2B);
    exec_want("ld3", 1, LedBank_LD3, 8'h00, 8'h23);
    exec_want("ld4", 1, LedBank_LD4, 8'h01, 8'h33);
    exec_want("ld5", 1, LedBank_LD5, 8'h80, 8'h13);
    exec_want("ld6", 1, LedBank_LD6, 8'h01, 8'h53);
    exec_want("ld7", 1, LedBank_LD7, 8'h03, 8'hD3);
    exec_want("nop1", 1, LedBank_NOP, 8'h55, 8'hD3);
    exec_want("en0", 0, LedBank_LDI, 8'hCC, 8'hD3);
    exec_want("ld1b", 1, LedBank_LD1, 8'h00, 8'hD1);
    exec_want("illegal", 1, 4'hF, 8'h10, 8'h00);
    check_eq("err_state", {7'b0, bus.state}, 8'h01);
    exec_want("err_ldi", 1, LedBank_LDI, 8'hD5, 8'h00);
    reset_pulse(8);
    exec_want("ldia5", 1, LedBank_LDI, 8'hA5, 8'hA5);
    exec_want("nopa5", 1, LedBank_NOP, 8'h00, 8'hA5);

    // Reset overlapping an LDI: the async clear must win on that edge.
    @(negedge clock);
    bus.inst_en = 1'b1;
    bus.inst    = {LedBank_LDI, 8'hFF};
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_clr", bus.leds, 8'h00);
    @(posedge clock);
    #1;
    check_eq("rst_ldi_leds", bus.leds, 8'h00);
    check_eq("rst_ldi_state", {7'b0, bus.state}, 8'h00);
    @(negedge clock);
    bus.inst_en = 1'b0;
    bus.inst    = 'x;
    reset       = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    check_eq("x_inst_known", {7'b0, $isunknown(bus.leds)}, 8'h00);
    check_eq("x_inst_leds", bus.leds, 8'h00);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) op = 4'($urandom_range(10, 15));
      else                           op = 4'($urandom_range(0, 9));
      en = ($urandom_range(0, 3) != 0);
      exec("rand", en, op, 8'($urandom_range(0, 255)));
      if (m_err && $urandom_range(0, 3) == 0) reset_pulse(int'($urandom_range(2, 12)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end

endmodule
